// File: rtl/v2f_pkg.sv
// Shared definitions for the v2f operand stage: occupancy state encoding
// and the width of the optional stall counter.
package v2f_pkg;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // neither register holds a pair
        ONE   = 2'd1,   // main register only
        FULL  = 2'd2    // main and skid registers
    } v2f_stage_state_e;

    localparam int V2F_STALL_CNT_W = 16;

endpackage

// File: rtl/v2f_skid_reg.sv
// Generic 2-entry skid buffer. The main register drives the output; the skid
// register catches the one extra word that can arrive while in_ready is still
// high after the consumer stalls. in_ready comes straight from a flop, so no
// combinational path runs from out_ready to in_ready.
module v2f_skid_reg
    import v2f_pkg::*;
#(
    parameter int WIDTH = 64
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    v2f_stage_state_e state_reg, state_next;

    logic [WIDTH-1:0] main_data_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             main_valid_reg;
    logic             skid_valid_reg;
    logic             in_ready_reg;

    logic in_xfer;
    logic out_xfer;
    logic load_main;
    logic load_skid;
    logic move_skid;

    assign in_xfer  = in_valid && in_ready_reg;
    assign out_xfer = main_valid_reg && out_ready;

    // Occupancy state, valid bits and the registered in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= EMPTY;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            main_valid_reg <= (state_next != EMPTY);
            skid_valid_reg <= (state_next == FULL);
            in_ready_reg   <= (state_next != FULL);
        end
    end

    // Next occupancy and which register gets written this cycle
    always_comb begin
        state_next = state_reg;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_xfer) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (in_xfer && out_xfer) begin
                    load_main  = 1'b1;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain can happen
                if (out_xfer) begin
                    move_skid  = 1'b1;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Data registers; they keep their last value when not written so the
    // outputs never go X while invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            if (load_main) begin
                main_data_reg <= in_data;
            end else if (move_skid) begin
                main_data_reg <= skid_data_reg;
            end
            if (load_skid) begin
                skid_data_reg <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

endmodule

// File: rtl/v2f_operand_stage.sv
// Registered valid/ready operand stage in front of the binary v2f primitives.
// Operands A and B travel bit-exact through one shared skid buffer.
// Optional feature macro: V2F_STAGE_STATS_EN adds a saturating stall counter.
module v2f_operand_stage
    import v2f_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_a,
    input  logic [B_WIDTH-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] out_a,
    output logic [B_WIDTH-1:0] out_b
`ifdef V2F_STAGE_STATS_EN
    ,
    output logic [V2F_STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int PAIR_W = A_WIDTH + B_WIDTH;

    logic [PAIR_W-1:0] pair_out;

    v2f_skid_reg #(
        .WIDTH (PAIR_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_a, in_b}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pair_out)
    );

    assign out_a = pair_out[PAIR_W-1:B_WIDTH];
    assign out_b = pair_out[B_WIDTH-1:0];

`ifdef V2F_STAGE_STATS_EN
    logic [V2F_STALL_CNT_W-1:0] stall_cnt_reg;

    // Count cycles where a pair waits on the consumer; stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + {{(V2F_STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    // No stall statistics in this build; the datapath is unchanged.
`endif

endmodule
